// File: rtl/serial_fadd_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package serial_fadd_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Counter must be able to hold NDIG itself.
    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/fadd_slice.sv
// DIGIT-wide ripple adder made of chained 1-bit full-adder cells.
module fadd_slice #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             ctop
);

    logic carry;

    always_comb begin
        carry = cin;
        ctop  = cin;
        sum   = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (i == int'(DIGIT) - 1) ctop = carry;
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/serial_fadd.sv
// Digit-serial WIDTH-bit adder with start/ready/done handshake.
// Define SERIAL_FADD_SUB_EN to add a SUB input for A - B.
module serial_fadd
    import serial_fadd_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
`ifdef SERIAL_FADD_SUB_EN
    input  logic             SUB,
`endif
    output logic             READY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
    localparam int unsigned CW   = cnt_width(WIDTH, DIGIT);

    if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_fadd: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_next;
    logic             carry_q, cout_q, ovf_q, done_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] s_sum;
    logic             s_cout, s_ctop;
    logic             b_inv, cin_eff;

    fadd_slice #(.DIGIT(DIGIT)) u_slice (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout),
        .ctop (s_ctop)
    );

    // Subtraction is folded into capture: B inverted, carry forced to 1.
`ifdef SERIAL_FADD_SUB_EN
    assign b_inv   = SUB;
    assign cin_eff = SUB ? 1'b1 : CIN;
`else
    assign b_inv   = 1'b0;
    assign cin_eff = CIN;
`endif

    always_comb begin
        sum_next = sum_q >> DIGIT;
        sum_next[WIDTH-1 -: DIGIT] = s_sum;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        a_q     <= A;
                        b_q     <= b_inv ? ~B : B;
                        carry_q <= cin_eff;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    sum_q   <= sum_next;
                    carry_q <= s_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NDIG - 1)) begin
                        cout_q  <= s_cout;
                        ovf_q   <= s_cout ^ s_ctop;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign READY = (state_q == IDLE);
    assign DONE  = done_q;
    assign SUM   = sum_q;
    assign COUT  = cout_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_serial_fadd.sv
// Directed self-checking bench for serial_fadd (WIDTH=8, DIGIT=2).
module tb_serial_fadd;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] A = '0, B = '0;
    logic       CIN = 1'b0;
`ifdef SERIAL_FADD_SUB_EN
    logic       SUB = 1'b0;
`endif
    logic       READY, DONE, COUT, OVF;
    logic [7:0] SUM;

    int total = 0;
    int bad   = 0;

    serial_fadd #(.WIDTH(8), .DIGIT(2)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
`ifdef SERIAL_FADD_SUB_EN
        .SUB   (SUB),
`endif
        .READY (READY),
        .DONE  (DONE),
        .SUM   (SUM),
        .COUT  (COUT),
        .OVF   (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        #3;
        total++; if (READY !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", READY); end
        total++; if (DONE !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", DONE); end
        total++; if ({SUM, COUT, OVF} !== 10'h000) begin
            bad++; $display("FAIL rst_outputs got=%h/%b/%b exp=00/0/0", SUM, COUT, OVF);
        end
        @(posedge CLK); #1 RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            total++; if (DONE !== 1'b0) begin bad++; $display("FAIL rst_release_done cycle=%0d got=%b exp=0", i, DONE); end
        end
    endtask

    // Start one op and check the DONE timing and results; inputs change #1 after an edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] es, input logic ec, input logic eo,
                          input string nm);
        int n = 0;
        while (READY !== 1'b1 && n < 20) begin @(posedge CLK); #1; n++; end
        total++; if (READY !== 1'b1) begin bad++; $display("FAIL %s ready_timeout got=%b exp=1", nm, READY); end
        A = a; B = b; CIN = cin; START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        total++; if (READY !== 1'b0) begin bad++; $display("FAIL %s busy_ready got=%b exp=0", nm, READY); end
        for (int e = 1; e <= 4; e++) begin
            @(posedge CLK); #1;
            total++; if (DONE !== (e == 4)) begin
                bad++; $display("FAIL %s done_edge%0d got=%b exp=%b", nm, e, DONE, e == 4);
            end
        end
        total++; if ({SUM, COUT, OVF} !== {es, ec, eo}) begin
            bad++; $display("FAIL %s result got=%h/%b/%b exp=%h/%b/%b", nm, SUM, COUT, OVF, es, ec, eo);
        end
        @(posedge CLK); #1;
        total++; if (DONE !== 1'b0 || READY !== 1'b1) begin
            bad++; $display("FAIL %s after_done done=%b ready=%b exp=0/1", nm, DONE, READY);
        end
        total++; if ({SUM, COUT, OVF} !== {es, ec, eo}) begin
            bad++; $display("FAIL %s held got=%h/%b/%b exp=%h/%b/%b", nm, SUM, COUT, OVF, es, ec, eo);
        end
    endtask

    task automatic test_add();
        run_op(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1, "add_5a_33");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        run_op(8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0, "add_7f_80");
    endtask

    task automatic test_back_to_back();
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "b2b_first");
        run_op(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, "b2b_second");
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int first = -1;
        A = 8'h5A; B = 8'h33; CIN = 1'b1; START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        @(posedge CLK); #1;
        A = 8'h11; B = 8'h11; CIN = 1'b0; START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) begin
                ndone++;
                if (first < 0) first = i;
                total++; if ({SUM, COUT, OVF} !== {8'h8E, 1'b0, 1'b1}) begin
                    bad++; $display("FAIL ignore_result got=%h/%b/%b exp=8e/0/1", SUM, COUT, OVF);
                end
            end
        end
        total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
        total++; if (first != 1) begin bad++; $display("FAIL ignore_done_cycle got=%0d exp=1", first); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        A = 8'hC3; B = 8'h5A; CIN = 1'b0; START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1 RST = 1'b1;
        #1;
        total++; if ({READY, DONE, SUM, COUT, OVF} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++; $display("FAIL midrst_outputs got=%b/%b/%h/%b/%b exp=1/0/00/0/0",
                            READY, DONE, SUM, COUT, OVF);
        end
        @(posedge CLK); #1 RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) ndone++;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL midrst_done got=%0d exp=0", ndone); end
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_midrst");
    endtask

`ifdef SERIAL_FADD_SUB_EN
    task automatic test_sub();
        SUB = 1'b1;
        run_op(8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0, "sub_10_20");
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "sub_80_01");
        SUB = 1'b0;
        run_op(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, "sub0_add");
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
`ifdef SERIAL_FADD_SUB_EN
        test_sub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
